move_recorder: RTL
==================

// Module: move_recorder
// PURPOSE
//  Front-end of the move-display path: debounces the entry keys, encodes each
//  accepted direction press as a 2-bit move code, packs moves into ord1..ord5
//  and keeps the move count. Asserts comp when the sequence is finished; the
//  7-seg display stage consumes cnt/ord1..ord5/comp unchanged.
// PARAMETERS
//  TICK_W     12   key sample period = 2**TICK_W clk cycles (same scan rate as display)
//  MAX_MOVES  70   capacity; fixed at 5 words x 14 moves x 2 bits
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  key        in   5   raw keys: [0]UE [1]SHITA [2]HIDARI [3]MIGI [4]finish/clear
//  cnt        out  28  number of recorded moves, 0..70
//  ord1..ord5 out  28  packed moves; move k in ord(k/14+1)[2*(k%14)+1 : 2*(k%14)]
//  comp       out  1   1 = sequence finished, outputs frozen
//  full       out  1   1 = cnt == MAX_MOVES
// BEHAVIOUR
//  Reset (async, rst_n=0): cnt=0, ord1..ord5=0, comp=0, full=0, state ENTRY,
//   tick counter 0, synchronisers and debounce state 0. Deassertion mid-entry
//   discards everything; no partial word survives.
//  Input path per key bit: 2-FF synchroniser -> sampled when tick counter wraps
//   to 0 -> debounced level = 1 after two consecutive high samples, 0 after two
//   consecutive low samples -> one-cycle press pulse on debounced 0->1.
//   Press latency: 2 sync cycles + up to 2 sample periods; holding a key gives
//   exactly one pulse.
//  Move codes: UE=2'd0, SHITA=2'd1, HIDARI=2'd2, MIGI=3'd3 -> 2'd3.
//  FSM ENTRY:
//   - direction pulse, cnt<70: write code at slot cnt, cnt<=cnt+1 (same edge,
//     visible 1 cycle after pulse); full<=1 when new cnt==70.
//   - several direction pulses same cycle: lowest index wins, others dropped.
//   - direction pulse, cnt==70: ignored, nothing changes.
//   - finish pulse, cnt>0: comp<=1, go DONE (finish beats a simultaneous
//     direction pulse; that move is dropped).
//   - finish pulse, cnt==0: ignored.
//  FSM DONE: outputs held; direction pulses ignored; finish pulse clears
//   cnt/ord/full to 0, comp<=0, go ENTRY, all in one cycle.
//  Slot writes touch only their 2 bits; unwritten slots stay 0.
//  Arithmetic: cnt is 7-bit internally, zero-extended to 28; word index =
//   cnt/14, bit offset = 2*(cnt%14), both computed by compare/subtract chain,
//   no divider.
// STRUCTURE
//  Shared package def.h: move codes UE/SHITA/HIDARI/MIGI, MOVES_PER_WORD=14,
//   MAX_MOVES, key index constants; display stage uses the same codes.
//  Sub-module key_debounce (one bit: sync, sample-enable input, level, pulse),
//   instantiated 5x; the shared tick counter lives in move_recorder.
//  FSM: 1 bit (ENTRY/DONE) as a named localparam pair.
// TESTING (bench uses TICK_W=2)
//  1 Reset, press UE,MIGI,SHITA,HIDARI -> cnt=4, ord1=28'h0000_0_9C? check
//    bits: [1:0]=0,[3:2]=3,[5:4]=1,[7:6]=2 -> ord1=28'h0000009C, comp=0.
//  2 Hold MIGI 100 cycles, bounce it 1-cycle glitches -> exactly one move;
//    glitch shorter than one sample period -> no move.
//  3 Enter 15 x HIDARI -> ord1=28'hAAAAAAA, ord2=28'h0000002, cnt=15.
//  4 Enter 72 moves -> cnt=70, full=1 after 70th, moves 71/72 change nothing.
//  5 Finish with cnt=0 -> comp stays 0; after 3 moves finish -> comp=1, further
//    directions ignored; finish again -> cnt=0, ord*=0, comp=0.
//  6 UE+MIGI pressed same sample -> one UE recorded; rst_n low mid-entry
//    (async, between clk edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/move_recorder_pkg.sv
// Shared move-entry definitions: move codes, capacity, key indices and the
// slot addressing helpers used to place a move inside the packed order words.
package move_recorder_pkg;

  localparam logic [6:0] MOVES_PER_WORD = 7'd14;
  localparam logic [6:0] MAX_MOVES      = 7'd70;
  localparam int         NUM_WORDS      = 5;
  localparam int         NUM_KEYS       = 5;

  localparam logic [1:0] MV_UE     = 2'd0;
  localparam logic [1:0] MV_SHITA  = 2'd1;
  localparam logic [1:0] MV_HIDARI = 2'd2;
  localparam logic [1:0] MV_MIGI   = 2'd3;

  localparam int KEY_UE     = 0;
  localparam int KEY_SHITA  = 1;
  localparam int KEY_HIDARI = 2;
  localparam int KEY_MIGI   = 3;
  localparam int KEY_FIN    = 4;

  // Word index = n / 14 via a compare chain (valid for n < 70).
  function automatic logic [2:0] slot_word(input logic [6:0] n);
    if (n >= 7'd56)      return 3'd4;
    else if (n >= 7'd42) return 3'd3;
    else if (n >= 7'd28) return 3'd2;
    else if (n >= 7'd14) return 3'd1;
    else                 return 3'd0;
  endfunction

  // Slot within the word = n % 14 via subtract chain.
  function automatic logic [3:0] slot_offset(input logic [6:0] n);
    logic [6:0] r;
    if (n >= 7'd56)      r = n - 7'd56;
    else if (n >= 7'd42) r = n - 7'd42;
    else if (n >= 7'd28) r = n - 7'd28;
    else if (n >= 7'd14) r = n - 7'd14;
    else                 r = n;
    return r[3:0];
  endfunction

endpackage

// File: rtl/move_recorder_key_debounce.sv
// One key bit: 2-FF synchroniser, two-sample debounce on the shared sample
// enable, and a single-cycle pulse on each debounced rising edge.
module key_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic raw,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic last_sample;
  logic level;

  // Level changes only after two consecutive agreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      last_sample <= 1'b0;
      level       <= 1'b0;
      pulse       <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sample_en) begin
        last_sample <= sync2;
        if (sync2 && last_sample) begin
          level <= 1'b1;
          pulse <= ~level;
        end else if (!sync2 && !last_sample) begin
          level <= 1'b0;
        end else begin
          level <= level;
        end
      end else begin
        last_sample <= last_sample;
        level       <= level;
      end
    end
  end

endmodule

// File: rtl/move_recorder.sv
// Move entry front-end: debounced keys become 2-bit move codes packed into
// five 28-bit order words, with a finish/clear key toggling ENTRY and DONE.
module move_recorder
  import move_recorder_pkg::*;
#(
  parameter int TICK_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  key,
  output logic [27:0] cnt,
  output logic [27:0] ord1,
  output logic [27:0] ord2,
  output logic [27:0] ord3,
  output logic [27:0] ord4,
  output logic [27:0] ord5,
  output logic        comp,
  output logic        full
);

  localparam logic ENTRY = 1'b0;
  localparam logic DONE  = 1'b1;

  logic [TICK_W-1:0]              tick;
  logic                           sample_en;
  logic [NUM_KEYS-1:0]            press;

  logic                           state_q, state_n;
  logic [6:0]                     cnt_q, cnt_n;
  logic [NUM_WORDS-1:0][27:0]     ord_q, ord_n;
  logic                           comp_q, comp_n;
  logic                           full_q, full_n;

  logic [1:0]                     code;
  logic [2:0]                     widx;
  logic [3:0]                     off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick <= '0;
    else        tick <= tick + 1'b1;
  end

  assign sample_en = (tick == '0);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .raw       (key[i]),
      .pulse     (press[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY;
      cnt_q   <= 7'd0;
      ord_q   <= '0;
      comp_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ord_q   <= ord_n;
      comp_q  <= comp_n;
      full_q  <= full_n;
    end
  end

  // Lowest-index direction wins when several pulse together.
  always_comb begin
    if (press[KEY_UE])          code = MV_UE;
    else if (press[KEY_SHITA])  code = MV_SHITA;
    else if (press[KEY_HIDARI]) code = MV_HIDARI;
    else                        code = MV_MIGI;
  end

  assign widx = slot_word(cnt_q);
  assign off  = slot_offset(cnt_q);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ord_n   = ord_q;
    comp_n  = comp_q;
    full_n  = full_q;
    case (state_q)
      ENTRY: begin
        if (press[KEY_FIN] && (cnt_q != 7'd0)) begin
          comp_n  = 1'b1;
          state_n = DONE;
        end else if ((|press[KEY_MIGI:KEY_UE]) && (cnt_q < MAX_MOVES)) begin
          ord_n[widx][{off, 1'b0} +: 2] = code;
          cnt_n  = cnt_q + 7'd1;
          full_n = ((cnt_q + 7'd1) == MAX_MOVES);
        end else begin
          state_n = ENTRY;
        end
      end
      DONE: begin
        if (press[KEY_FIN]) begin
          cnt_n   = 7'd0;
          ord_n   = '0;
          comp_n  = 1'b0;
          full_n  = 1'b0;
          state_n = ENTRY;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  assign cnt  = {21'd0, cnt_q};
  assign ord1 = ord_q[0];
  assign ord2 = ord_q[1];
  assign ord3 = ord_q[2];
  assign ord4 = ord_q[3];
  assign ord5 = ord_q[4];
  assign comp = comp_q;
  assign full = full_q;

endmodule
